// File: rtl/gaussian_pkg.sv
// Shared types and constants for the Gaussian line-buffer scheduler.
package gaussian_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int PIX_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } sched_state_t;

  // Address width for a row of the given length (at least one bit).
  function automatic int col_width(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

endpackage

// File: rtl/gaussian_line_buf.sv
// Two row buffers (previous row / current row) with asynchronous read and
// one synchronous write port each. Both arrays share the column address,
// since the scheduler always reads and rewrites the same column.
module gaussian_line_buf
  import gaussian_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic                          clk,
  input  logic [col_width(DEPTH)-1:0]   i_addr,
  input  logic                          i_we_a,
  input  logic [PIX_W-1:0]              i_wd_a,
  input  logic                          i_we_b,
  input  logic [PIX_W-1:0]              i_wd_b,
  output logic [PIX_W-1:0]              o_rd_a,
  output logic [PIX_W-1:0]              o_rd_b
);

  logic [PIX_W-1:0] r_mem_a [DEPTH];
  logic [PIX_W-1:0] r_mem_b [DEPTH];

  // Row r-1 storage write port.
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem_a[i_addr] <= i_wd_a;
  end

  // Row r storage write port.
  always_ff @(posedge clk) begin
    if (i_we_b) r_mem_b[i_addr] <= i_wd_b;
  end

  assign o_rd_a = r_mem_a[i_addr];
  assign o_rd_b = r_mem_b[i_addr];

endmodule

// File: rtl/gaussian_line_sched.sv
// Line-buffer scheduler feeding the three-row Gaussian filter with
// vertically aligned up/centre/low pixel triples.
// Build option: GAUSSIAN_SCHED_ZERO_BORDER_EN selects zero top/bottom
// borders instead of replicated border rows.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FILL  | accepting row 0 into both line buffers, no filter output
// S_RUN   | accepting rows 1..IMG_H-1, one filter word per pixel
// S_FLUSH | no input, emitting the last output row from the buffers
// S_DRAIN | waiting for the filter to take the final word
module gaussian_line_sched
  import gaussian_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        start,
  input  logic [PIX_W-1:0]            pix_in,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic                        flt_full,
  output logic [PIX_W-1:0]            dui,
  output logic [PIX_W-1:0]            dci,
  output logic [PIX_W-1:0]            dli,
  output logic                        flt_wr_en,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(IMG_H+1)-1:0]  row_cnt
);

  localparam int COL_W = col_width(IMG_W);
  localparam int ROW_W = $clog2(IMG_H+1);

  sched_state_t     r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row_cnt;
  logic [PIX_W-1:0] r_dui;
  logic [PIX_W-1:0] r_dci;
  logic [PIX_W-1:0] r_dli;
  logic             r_wr_en;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_pix_ready;
  logic             w_accept;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_load;
  logic [PIX_W-1:0] w_dli_next;
  logic             w_we_a;
  logic             w_we_b;
  logic [PIX_W-1:0] w_wd_a;
  logic [PIX_W-1:0] w_wd_b;
  logic [PIX_W-1:0] w_rd_a;
  logic [PIX_W-1:0] w_rd_b;

  gaussian_line_buf #(
    .DEPTH (IMG_W)
  ) u_line_buf (
    .clk    (clk),
    .i_addr (r_col),
    .i_we_a (w_we_a),
    .i_wd_a (w_wd_a),
    .i_we_b (w_we_b),
    .i_wd_b (w_wd_b),
    .o_rd_a (w_rd_a),
    .o_rd_b (w_rd_b)
  );

  // In RUN the source stalls with the filter so a pixel never outruns its word.
  assign w_pix_ready = (r_state == S_FILL) || ((r_state == S_RUN) && !flt_full);
  assign w_accept    = pix_valid && w_pix_ready;
  assign w_last_col  = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row  = (r_row_cnt == ROW_W'(IMG_H - 1));
  assign w_load      = ((r_state == S_RUN) && w_accept) ||
                       ((r_state == S_FLUSH) && !flt_full);

  // Low pixel of the next word: live pixel in RUN, bottom border in FLUSH.
  always_comb begin
    w_dli_next = pix_in;
    if (r_state != S_RUN) begin
`ifdef GAUSSIAN_SCHED_ZERO_BORDER_EN
      w_dli_next = '0;
`else
      w_dli_next = w_rd_b;
`endif
    end
  end

  // Line-buffer update: FILL seeds both rows, RUN shifts row r into row r-1.
  always_comb begin
    w_we_a = 1'b0;
    w_we_b = 1'b0;
    w_wd_a = pix_in;
    w_wd_b = pix_in;
    if (w_accept && (r_state == S_FILL)) begin
      w_we_a = 1'b1;
      w_we_b = 1'b1;
`ifdef GAUSSIAN_SCHED_ZERO_BORDER_EN
      w_wd_a = '0;
`else
      w_wd_a = pix_in;
`endif
    end else if (w_accept && (r_state == S_RUN)) begin
      w_we_a = 1'b1;
      w_we_b = 1'b1;
      w_wd_a = w_rd_b;
      w_wd_b = pix_in;
    end
  end

  // Sequencing FSM with its registered filter-side outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row_cnt    <= '0;
      r_dui        <= '0;
      r_dci        <= '0;
      r_dli        <= '0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // The output word only moves when the filter is clocking (ce = !full).
      if (!flt_full) begin
        r_wr_en <= w_load;
        if (w_load) begin
          r_dui <= w_rd_a;
          r_dci <= w_rd_b;
          r_dli <= w_dli_next;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FILL;
            r_busy    <= 1'b1;
            r_col     <= '0;
            r_row_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_col) begin
              r_col     <= '0;
              r_row_cnt <= r_row_cnt + ROW_W'(1);
              r_state   <= S_RUN;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_col) begin
              r_col     <= '0;
              r_row_cnt <= r_row_cnt + ROW_W'(1);
              if (w_last_row) r_state <= S_FLUSH;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (!flt_full) begin
            if (w_last_col) begin
              r_col   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_wr_en && !flt_full) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready  = w_pix_ready;
  assign dui        = r_dui;
  assign dci        = r_dci;
  assign dli        = r_dli;
  assign flt_wr_en  = r_wr_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign row_cnt    = r_row_cnt;

endmodule

// File: doc/gaussian_line_sched.md
# gaussian_line_sched

Line-buffer scheduler that sequences a raster pixel stream into the three-row Gaussian filter datapath. It buffers two image rows and presents vertically aligned up/centre/low pixel triples, with a write strobe, to the filter's `dui`/`dci`/`dli`/`wr_en` inputs. It honours the filter's `full` backpressure and replicates the top and bottom border rows. It sits between the frame source (DMA/camera stream) and the filter.

## Interface
- `IMG_W`, default 640: pixels per row, minimum 2.
- `IMG_H`, default 480: rows per frame, minimum 2.
- `clk` in 1: clock.
- `srst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle frame start request; only honoured in IDLE.
- `pix_in` in 8: input pixel, raster order.
- `pix_valid` in 1: `pix_in` valid.
- `pix_ready` out 1: pixel accepted when `pix_valid && pix_ready`.
- `flt_full` in 1: filter `full`.
- `dui`, `dci`, `dli` out 8 each: up/centre/low pixel to the filter.
- `flt_wr_en` out 1: filter `wr_en`.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle end-of-frame pulse.
- `row_cnt` out clog2(IMG_H+1): input row currently being accepted.

## Operation
- **Line buffers.**
  - `lb_a[x]` holds row r-1; `lb_b[x]` holds row r.
  - Column counter `col` runs 0..IMG_W-1 and wraps to 0 at row end, incrementing `row_cnt`.
- **State machine.**
  - IDLE: `start` → FILL. `busy`=1 from the cycle after `start`.
  - FILL (input row 0): each accepted pixel is written to both `lb_a[col]` and `lb_b[col]` (replicate). No filter output. At last column → RUN.
  - RUN (input rows 1..IMG_H-1): an accepted pixel `p` loads the output register with `dui=lb_a[col]`, `dci=lb_b[col]`, `dli=p`. It then writes `lb_a[col]<=lb_b[col]` and `lb_b[col]<=p`. Last column of row IMG_H-1 → FLUSH.
  - FLUSH (no input, `pix_ready`=0): per column, load `dui=lb_a[col]`, `dci=lb_b[col]`, `dli=lb_b[col]` (bottom replicate). After the last column → DRAIN.
  - DRAIN: wait until the final word is taken (`flt_wr_en && !flt_full`) → IDLE. `busy` falls and `frame_done` pulses in the cycle after the final word is taken.
- **Handshake.**
  - `pix_ready = (FILL) || (RUN && !flt_full)`.
  - The output register and `flt_wr_en` change only when `flt_full`=0. While `flt_full`=1, all of `dui`/`dci`/`dli`/`flt_wr_en` hold. This matches the filter's `ce=!full` gating, so no word is lost or duplicated.
  - `flt_wr_en` clears when its word is taken and no new word loads in the same cycle.
- **Output count.** Exactly IMG_W×IMG_H filter writes per frame, in raster order of output rows 0..IMG_H-1.
- **Not this block's job.** Horizontal borders (row-to-row seam in the filter's horizontal pipeline) are handled downstream.
- **Boundary conditions.**
  - `start` while `busy` is ignored.
  - `pix_valid` outside FILL/RUN is ignored.
  - `srst` mid-frame: next cycle the block is in IDLE and all outputs are at reset values. Line-buffer contents are not cleared; they are overwritten by the next FILL.

## Timing
- Reset values: `pix_ready`=0, `dui`=`dci`=`dli`=0, `flt_wr_en`=0, `busy`=0, `frame_done`=0, `row_cnt`=0.
- RUN latency: pixel accepted at cycle t → word presented (`flt_wr_en`=1) at t+1.
- FLUSH: one word per non-full cycle. Throughput is 1 word/cycle with no backpressure.
- First filter word appears 1 cycle after the first pixel of input row 1 is accepted.
- Frame cycle count with no stalls: 2 (start→FILL) + IMG_W×IMG_H + IMG_W + 1.

## Configuration
- `GAUSSIAN_SCHED_ZERO_BORDER_EN` defined: zero borders. FILL writes 0 to `lb_a`, so top-row words have `dui`=0. FLUSH drives `dli`=0.
- Undefined (default): replicate borders as described under Operation.

## Structure
- `gaussian_pkg` holds:
  - the state enum (IDLE, FILL, RUN, FLUSH, DRAIN);
  - default `IMG_W`/`IMG_H` constants;
  - the pixel width constant (8).
- Sub-module `gaussian_line_buf`: two IMG_W×8 arrays with asynchronous read and one synchronous write port each, with per-array write enables and write data. It maps to distributed RAM.

## Test plan
Benches use IMG_W=4, IMG_H=3, with pixel value = row×16+col (rows 00..03, 10..13, 20..23).
- **Reset:** hold `srst` 2 cycles → all outputs at reset values, state IDLE.
- **Full frame, no stall:**
  - Exactly 12 `flt_wr_en` words.
  - Word 0 = (00,00,10).
  - Word 5 = (01,11,21).
  - Word 11 = (13,23,23).
  - `frame_done` pulses once, then `busy`=0.
- **Backpressure:** `flt_full`=1 for 5 cycles during output row 1 → outputs frozen, `pix_ready`=0, word sequence identical to the no-stall run.
- **Start while busy:** `start` pulse while busy → ignored, single frame. `start` in IDLE → new frame begins.
- **Mid-frame reset:** `srst` in RUN at column 2 → IDLE next cycle. Following frame output is bit-exact with the no-stall run.
- **`GAUSSIAN_SCHED_ZERO_BORDER_EN`:** word 0 = (00,00,10), word 1 = (00,01,11), word 11 = (13,23,00).
